// File: rtl/ram64x8_bist.sv
// March-style BIST controller for a 64x8 single-port RAM (M0..M3).
// Ports: ck, rst_n, start -> busy/done/pass/fail_*; mem_* drives the RAM.
module ram64x8_bist #(
  parameter logic [7:0] PAT = 8'h55
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_addr,
  output logic [7:0] fail_data,
  output logic [1:0] fail_elem,
  output logic       mem_wen,
  output logic [5:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE, WR0, RD, CMP, WR, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] elem_q, elem_d;
  logic [5:0] addr_q, addr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [5:0] faddr_q, faddr_d;
  logic [7:0] fdata_q, fdata_d;
  logic [1:0] felem_q, felem_d;
  logic       wen_q, wen_d;
  logic [7:0] din_q, din_d;

  logic [7:0] exp_pat;
  logic [7:0] wr_pat;

  // M2 reads back ~PAT; M1 writes ~PAT
  assign exp_pat = (elem_q == 2'd2) ? ~PAT : PAT;
  assign wr_pat  = (elem_q == 2'd1) ? ~PAT : PAT;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    felem_d = felem_q;
    wen_d   = 1'b0;
    din_d   = din_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WR0;
          elem_d  = 2'd0;
          addr_d  = 6'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          faddr_d = 6'd0;
          fdata_d = 8'd0;
          felem_d = 2'd0;
          wen_d   = 1'b1;
          din_d   = PAT;
        end
      end
      WR0: begin
        if (addr_q == 6'd63) begin
          state_d = RD;
          elem_d  = 2'd1;
          addr_d  = 6'd0;
        end else begin
          addr_d = addr_q + 6'd1;
          wen_d  = 1'b1;
          din_d  = PAT;
        end
      end
      RD: begin
        state_d = CMP;
      end
      CMP: begin
        if (mem_dout != exp_pat) begin
          // first mismatch: stop, pending write is dropped
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          faddr_d = addr_q;
          fdata_d = mem_dout;
          felem_d = elem_q;
        end else if (elem_q != 2'd3) begin
          state_d = WR;
          wen_d   = 1'b1;
          din_d   = wr_pat;
        end else if (addr_q == 6'd0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else begin
          state_d = RD;
          addr_d  = addr_q - 6'd1;
        end
      end
      WR: begin
        state_d = RD;
        if (elem_q == 2'd1) begin
          if (addr_q == 6'd63) begin
            elem_d = 2'd2;
            addr_d = 6'd63;
          end else begin
            addr_d = addr_q + 6'd1;
          end
        end else begin
          if (addr_q == 6'd0) begin
            elem_d = 2'd3;
            addr_d = 6'd63;
          end else begin
            addr_d = addr_q - 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= 2'd0;
      addr_q  <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      faddr_q <= 6'd0;
      fdata_q <= 8'd0;
      felem_q <= 2'd0;
      wen_q   <= 1'b0;
      din_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      felem_q <= felem_d;
      wen_q   <= wen_d;
      din_q   <= din_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;
  assign fail_elem = felem_q;
  assign mem_wen   = wen_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;

endmodule

// File: tb/tb_ram64x8_bist.sv
// Bench for ram64x8_bist: RAM model with fault modes and read latency,
// scoreboard of expected run outcomes popped when done rises.
module tb_ram64x8_bist;

  logic       ck = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [5:0] fail_addr;
  logic [7:0] fail_data;
  logic [1:0] fail_elem;
  logic       mem_wen;
  logic [5:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  ram64x8_bist dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_elem (fail_elem),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 ck = ~ck;

  logic [7:0] mem [64];
  logic [7:0] rv;
  logic [7:0] dout_r;
  int         fault = 0;
  bit         reg_mode = 1'b0;

  always_comb begin
    rv = mem[mem_addr];
    if (fault == 1 && mem_addr == 6'h2A) rv[3] = 1'b0;
    if (fault == 2 && mem_addr == 6'h00) rv = 8'h00;
  end

  assign mem_dout = reg_mode ? dout_r : rv;

  always @(posedge ck) begin
    if (mem_wen) mem[mem_addr] <= mem_din;
    dout_r <= rv;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    bit         p;
    logic [1:0] e;
    logic [5:0] a;
    logic [7:0] d;
    int         cyc;
    int         wr;
    int         wr0;
  } exp_t;

  exp_t sb[$];

  task automatic expect_run(input bit p, input logic [1:0] e,
                            input logic [5:0] a, input logic [7:0] d,
                            input int cyc, input int wr, input int wr0);
    exp_t x;
    x.p = p; x.e = e; x.a = a; x.d = d;
    x.cyc = cyc; x.wr = wr; x.wr0 = wr0;
    sb.push_back(x);
  endtask

  // hold = 0: one-cycle start pulse; else start kept high until cycle hold
  task automatic run(input int hold);
    exp_t x;
    int   cyc, wr, wr0, bsy;
    bit   got;
    @(negedge ck);
    start = 1'b1;
    @(posedge ck);
    cyc = 1; wr = 0; wr0 = 0; bsy = 0; got = 1'b0;
    #1;
    if (hold == 0) start = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin
      @(negedge ck);
      if (hold != 0 && cyc >= hold) start = 1'b0;
      if (cyc == 1) begin
        check("c1_busy", busy, 1);
        check("c1_done", done, 0);
        check("c1_pass", pass, 0);
        check("c1_faddr", fail_addr, 0);
        check("c1_wen", mem_wen, 1);
        check("c1_addr", mem_addr, 0);
        check("c1_din", mem_din, 8'h55);
      end
      if (done) begin
        got = 1'b1;
        x = sb.pop_front();
        check("done_cyc", cyc, x.cyc);
        check("pass", pass, x.p);
        check("busy_end", busy, 0);
        check("fail_elem", fail_elem, x.e);
        check("fail_addr", fail_addr, x.a);
        check("fail_data", fail_data, x.d);
        check("busy_cycles", bsy, x.cyc - 1);
        check("writes", wr, x.wr);
        check("writes_a0", wr0, x.wr0);
      end else begin
        if (busy) bsy++;
        if (mem_wen) begin
          wr++;
          if (mem_addr == 6'd0) wr0++;
        end
        @(posedge ck);
        cyc++;
      end
    end
    if (!got) begin
      check("timeout", 0, 1);
      void'(sb.pop_front());
    end else begin
      repeat (3) @(negedge ck);
      check("hold_done", done, 1);
      check("hold_pass", pass, x.p);
      check("hold_wen", mem_wen, 0);
    end
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #20;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);
    @(negedge ck);
    rst_n = 1'b1;
    repeat (4) @(negedge ck);
    check("idle_busy", busy, 0);
    check("idle_wen", mem_wen, 0);

    // fault-free, combinational read
    expect_run(1'b1, 2'd0, 6'h00, 8'h00, 577, 192, 3);
    run(0);

    // bit 3 stuck-at-0 at 0x2A: caught reading ~PAT in M2
    fault = 1;
    expect_run(1'b0, 2'd2, 6'h2A, 8'hA2, 322, 149, 2);
    run(0);

    // address 0 reads zero: caught at first M1 read
    fault = 2;
    expect_run(1'b0, 2'd1, 6'h00, 8'h00, 67, 64, 1);
    run(0);
    fault = 0;

    // reset in M2
    @(negedge ck);
    start = 1'b1;
    @(posedge ck);
    #1 start = 1'b0;
    repeat (300) @(posedge ck);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_pass", pass, 0);
    check("mid_wen", mem_wen, 0);
    check("mid_addr", mem_addr, 0);
    check("mid_din", mem_din, 0);
    check("mid_faddr", fail_addr, 0);
    check("mid_fdata", fail_data, 0);
    check("mid_felem", fail_elem, 0);
    repeat (3) @(negedge ck);
    check("mid_wen2", mem_wen, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge ck);
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    expect_run(1'b1, 2'd0, 6'h00, 8'h00, 577, 192, 3);
    run(0);

    // start held while busy, then re-pulsed in DONE
    expect_run(1'b1, 2'd0, 6'h00, 8'h00, 577, 192, 3);
    run(500);
    expect_run(1'b1, 2'd0, 6'h00, 8'h00, 577, 192, 3);
    run(0);

    // registered-read RAM
    reg_mode = 1'b1;
    expect_run(1'b1, 2'd0, 6'h00, 8'h00, 577, 192, 3);
    run(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram64x8_bist.md
RAM64X8_BIST -- requirements
Module: ram64x8_bist

Interface
REQ-001 Parameter: PAT, default 8'h55, base test pattern; its bitwise complement is the alternate pattern.
REQ-002 ck  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to run a test; sampled only in IDLE or DONE.
REQ-005 busy  output  1  test in progress.
REQ-006 done  output  1  test finished; held until next accepted start or reset.
REQ-007 pass  output  1  valid while done=1; 1 = no mismatch.
REQ-008 fail_addr  output  6  address of first mismatch.
REQ-009 fail_data  output  8  data read at first mismatch.
REQ-010 fail_elem  output  2  march element index (1..3) of first mismatch.
REQ-011 mem_wen  output  1  write enable to RAM port; RAM writes din at addr on rising ck when high.
REQ-012 mem_addr  output  6  RAM address.
REQ-013 mem_din  output  8  RAM write data.
REQ-014 mem_dout  input  8  RAM read data.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States: IDLE, WR0, RD, CMP, WR, DONE; a 2-bit element counter and a 6-bit address counter SHALL index the march.
REQ-017 March sequence, fixed:
- M0: ascending 0..63, write PAT.
- M1: ascending 0..63, read expect PAT, then write ~PAT.
- M2: descending 63..0, read expect ~PAT, then write PAT.
- M3: descending 63..0, read expect PAT.
REQ-018 Per-address timing:
- M0: 1 cycle (WR0, mem_wen=1).
- M1, M2: 3 cycles (RD: mem_wen=0; CMP: mem_wen=0, same address held; WR: mem_wen=1, same address).
- M3: 2 cycles (RD, CMP).
REQ-019 Comparison SHALL use mem_dout in the CMP cycle, with mem_addr held constant across RD and CMP; this supports both combinational-read and 1-cycle registered-read RAMs.
REQ-020 mem_wen SHALL be 1 only in WR0 and WR cycles; mem_din SHALL equal the element write pattern in those cycles and is don't-care otherwise.
REQ-021 Address wrap: after address 63 (ascending) or 0 (descending), the block SHALL advance to the next element with the address loaded at that element's start value; there is no idle cycle between elements.
REQ-022 start=1 in IDLE or DONE SHALL, on that edge, clear done/pass/fail_* and set busy=1; the first M0 write SHALL occur in the next cycle (cycle 1).
REQ-023 Fault-free run: test cycles SHALL be 1..576 (64+192+192+128); done=1, pass=1, busy=0 from cycle 577.
REQ-024 On the first mismatch in CMP, the block SHALL on the next edge enter DONE with pass=0, latch fail_addr/fail_data/fail_elem, and skip any pending write (mem_wen stays 0).
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 In DONE, outputs SHALL hold until start=1 (restart per REQ-022) or reset.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counters 0, and busy, done, pass, mem_wen to 0; mem_addr, mem_din, fail_addr, fail_data, fail_elem to 0; this applies mid-test as well, and no further write SHALL occur.
REQ-028 After rst_n deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-029 Fault-free 64x8 RAM model, start pulse -> mem_wen pulses=64+64+64, done=1 and pass=1 at cycle 577, busy=1 on cycles 1..576.
REQ-030 RAM with bit 3 stuck-at-0 at address 0x2A, PAT=8'h55 -> done=1, pass=0, fail_elem=2, fail_addr=6'h2A, fail_data=8'hA2.
REQ-031 RAM with address 0x00 always reading 8'h00 -> fail_elem=1, fail_addr=6'h00, fail_data=8'h00; no write to address 0 after the mismatch.
REQ-032 rst_n asserted during M2 -> all outputs 0 asynchronously; start after release -> full 576-cycle run, pass=1.
REQ-033 start held high during a run, then pulsed again in DONE -> no effect while busy; second run restarts with done cleared and passes.
REQ-034 Registered-read RAM model (1-cycle read latency), fault-free -> pass=1 at cycle 577.
